// File: rtl/seq_bit_packer_pkg.sv
// rtl/seq_bit_packer_pkg.sv - shared defaults, ones-count width derivation and popcount helper
package seq_bit_packer_pkg;

  // Default packed word width
  localparam int SEQ_W_DEFAULT = 8;

  // Width of a count that must hold 0..w inclusive
  function automatic int seq_cw(input int w);
    return $clog2(w + 1);
  endfunction

  // Number of set bits in a word of up to 32 bits (narrower words are zero-extended)
  function automatic logic [5:0] seq_popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_bit_shifter.sv
// rtl/seq_bit_shifter.sv - serial bit collector with early flush; flags a completed word combinationally
module seq_bit_shifter
  import seq_bit_packer_pkg::*;
#(
  parameter int W = SEQ_W_DEFAULT
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         bit_in,
  input  logic         bit_vld,
  input  logic         flush,
  output logic [W-1:0] word,
  output logic         word_done
);

  localparam int               CNT_W    = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  logic [W-1:0]     sr;
  logic [CNT_W-1:0] cnt;

  // The word as it stands after this edge's bit lands, so completion and load share one edge
  always_comb begin
    word = sr;
    if (bit_vld) begin
      word[cnt] = bit_in;
    end
  end

  // A word completes on its last bit, or on flush when at least one bit is held (including this edge's)
  always_comb begin
    word_done = (bit_vld && (cnt == CNT_LAST)) || (flush && ((cnt != '0) || bit_vld));
  end

  // Shift state: cleared on completion so unfilled positions of a flushed word read as 0
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (word_done) begin
      sr  <= '0;
      cnt <= '0;
    end else if (bit_vld) begin
      sr  <= word;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_bit_packer.sv
// rtl/seq_bit_packer.sv - packs qualified serial bits into words with ones count; optional out_par under SEQ_BIT_PACKER_PARITY_EN
module seq_bit_packer
  import seq_bit_packer_pkg::*;
#(
  parameter int W  = SEQ_W_DEFAULT,
  parameter int CW = seq_cw(W)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          bit_in,
  input  logic          bit_vld,
  input  logic          flush,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_ones,
  output logic          out_vld,
  input  logic          out_rdy,
`ifdef SEQ_BIT_PACKER_PARITY_EN
  output logic          overflow,
  output logic          out_par
`else
  output logic          overflow
`endif
);

  logic [W-1:0] word;
  logic         word_done;
  logic         hold_free;

  seq_bit_shifter #(
    .W(W)
  ) u_shifter (
    .Clk      (Clk),
    .Rst      (Rst),
    .bit_in   (bit_in),
    .bit_vld  (bit_vld),
    .flush    (flush),
    .word     (word),
    .word_done(word_done)
  );

  // Holding register accepts a new word when empty or being drained on this same edge
  always_comb begin
    hold_free = !out_vld || out_rdy;
  end

  // Holding register and handshake: load on completion, drop with sticky overflow when stalled
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_data <= '0;
      out_ones <= '0;
      out_vld  <= 1'b0;
      overflow <= 1'b0;
    end else if (word_done) begin
      if (hold_free) begin
        out_data <= word;
        out_ones <= CW'(seq_popcount(32'(word)));
        out_vld  <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (out_vld && out_rdy) begin
      out_vld <= 1'b0;
    end
  end

`ifdef SEQ_BIT_PACKER_PARITY_EN
  // Parity travels with the word and holds while the consumer stalls
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_par <= 1'b0;
    end else if (word_done && hold_free) begin
      out_par <= ^word;
    end
  end
`endif

endmodule

// File: tb/tb_seq_bit_packer.sv
// tb/tb_seq_bit_packer.sv - scoreboard bench for seq_bit_packer (W=8), parity checked when SEQ_BIT_PACKER_PARITY_EN is defined
module tb_seq_bit_packer;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          Clk;
  logic          Rst;
  logic          bit_in;
  logic          bit_vld;
  logic          flush;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_ones;
  logic          out_vld;
  logic          out_rdy;
  logic          overflow;
`ifdef SEQ_BIT_PACKER_PARITY_EN
  logic          out_par;
`endif

  seq_bit_packer #(
    .W (W),
    .CW(CW)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .bit_in  (bit_in),
    .bit_vld (bit_vld),
    .flush   (flush),
    .out_data(out_data),
    .out_ones(out_ones),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
`ifdef SEQ_BIT_PACKER_PARITY_EN
    .overflow(overflow),
    .out_par (out_par)
`else
    .overflow(overflow)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [W-1:0] m_sr;
  int           m_cnt;
  logic         m_vld;
  logic         m_ovf;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ones_of(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n++;
    return n;
  endfunction

  // One clock: drive inputs, score a word being taken, advance the model, then check state
  task automatic cyc(input logic rst, input logic v, input logic b, input logic f, input logic r);
    logic [W-1:0] w;
    logic [W-1:0] e;
    logic         done;
    Rst = rst; bit_vld = v; bit_in = b; flush = f; out_rdy = r;
    #1;
    if (!rst && out_vld && out_rdy) begin
      chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
        chk("out_ones", 32'(out_ones), 32'(ones_of(e)));
`ifdef SEQ_BIT_PACKER_PARITY_EN
        chk("out_par", 32'(out_par), 32'(^e));
`endif
      end
    end
    @(posedge Clk);
    if (rst) begin
      m_sr = '0; m_cnt = 0; m_vld = 1'b0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      w = m_sr;
      done = 1'b0;
      if (v) begin
        w[m_cnt] = b;
        if (m_cnt == W - 1) done = 1'b1;
      end
      if (f && (m_cnt > 0 || v)) done = 1'b1;
      if (done) begin
        if (!m_vld || r) begin
          exp_q.push_back(w);
          m_vld = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
        m_sr = '0;
        m_cnt = 0;
      end else begin
        if (v) begin
          m_sr = w;
          m_cnt++;
        end
        if (m_vld && r) m_vld = 1'b0;
      end
    end
    @(negedge Clk);
    chk("out_vld", 32'(out_vld), 32'(m_vld));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic feed(input logic [W-1:0] bits, input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, bits[i], 1'b0, r);
  endtask

  initial begin
    logic [W-1:0] pat;
    Rst = 1'b1; bit_vld = 1'b0; bit_in = 1'b0; flush = 1'b0; out_rdy = 1'b0;
    m_sr = '0; m_cnt = 0; m_vld = 1'b0; m_ovf = 1'b0;
    @(negedge Clk);

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_ones", 32'(out_ones), 32'h0);
    chk("rst_vld", 32'(out_vld), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);

    // Basic word: 1,0,1,1,0,0,1,0 -> 0x4D
    pat = 8'h4D;
    feed(pat, 8, 1'b1);
    chk("basic_data", 32'(out_data), 32'h4D);
    chk("basic_ones", 32'(out_ones), 32'd4);
    chk("basic_vld", 32'(out_vld), 32'd1);
`ifdef SEQ_BIT_PACKER_PARITY_EN
    chk("basic_par", 32'(out_par), 32'd0);
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_one_cycle", 32'(out_vld), 32'd0);

    // Back-to-back all-ones words with no gap
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      if (i == 7 || i == 15) begin
        chk("b2b_data", 32'(out_data), 32'hFF);
        chk("b2b_ones", 32'(out_ones), 32'd8);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Stall: A=0x0F held, B=0xF0 dropped
    pat = 8'h0F;
    feed(pat, 8, 1'b0);
    pat = 8'hF0;
    feed(pat, 8, 1'b0);
    chk("stall_data", 32'(out_data), 32'h0F);
    chk("stall_ovf", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_drained", 32'(out_vld), 32'd0);
    chk("stall_ovf_sticky", 32'(overflow), 32'd1);

    // Flush partial word
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pat = 8'h07;
    feed(pat, 3, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_data", 32'(out_data), 32'h07);
    chk("flush_ones", 32'(out_ones), 32'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Idle flush does nothing
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_idle", 32'(out_vld), 32'd0);
    // Flush together with the 8th bit: one word only
    pat = 8'h81;
    feed(pat, 7, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("flush_full_data", 32'(out_data), 32'h81);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_single_word", 32'(out_vld), 32'd0);

    // Reset mid-word
    pat = 8'h1F;
    feed(pat, 5, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pat = 8'h00;
    feed(pat, 8, 1'b1);
    chk("midrst_data", 32'(out_data), 32'h00);
    chk("midrst_ones", 32'(out_ones), 32'd0);
    chk("midrst_vld", 32'(out_vld), 32'd1);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Simultaneous drain and load
    pat = 8'hAA;
    feed(pat, 8, 1'b0);
    pat = 8'h55;
    feed(pat, 7, 1'b0);
    cyc(1'b0, 1'b1, pat[7], 1'b0, 1'b1);
    chk("swap_vld", 32'(out_vld), 32'd1);
    chk("swap_data", 32'(out_data), 32'h55);
    chk("swap_ovf", 32'(overflow), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
